// File: rtl/tone_divgen.sv
// tone_divgen: note code -> clock divider (restoring division) -> square-wave tone
// Ports:
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    note_valid in   note request strobe
//    note       in   note code: 0 rest, 1..21 pitch, anything else rest
//    note_ready out  request can be accepted (FSM idle)
//    divnum     out  tone period in clk cycles, 0 = rest
//    div_valid  out  one-cycle pulse when divnum is updated
//    busy       out  division in progress
//    tone_out   out  registered square-wave output
module tone_divgen #(
   parameter int CLK_HZ = 50_000_000,
   parameter int DIV_W  = 32,
   parameter int NOTE_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              note_valid,
   input  logic [NOTE_W-1:0] note,
   output logic              note_ready,
   output logic [DIV_W-1:0]  divnum,
   output logic              div_valid,
   output logic              busy,
   output logic              tone_out
);
   localparam int BW = $clog2(DIV_W);
   localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
   localparam logic [10:0] FTAB [32] = '{
      11'd0,    11'd262,  11'd294,  11'd330,  11'd349,  11'd392,  11'd440,  11'd494,
      11'd523,  11'd587,  11'd659,  11'd699,  11'd784,  11'd880,  11'd988,
      11'd1050, 11'd1175, 11'd1319, 11'd1397, 11'd1568, 11'd1760, 11'd1976,
      11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0
   };

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state, next;

   logic [10:0]       freq;
   logic              pitch;
   logic [DIV_W-1:0]  dq, rem, dsr, cnt;
   logic [BW-1:0]     bcnt;
   logic [DIV_W:0]    rsh, trial;

   // codes with any bit above bit 4 set are out of table range and therefore rests
   assign freq  = ((note >> 5) == '0) ? FTAB[note[4:0]] : 11'd0;
   assign pitch = freq != 11'd0;

   assign note_ready = state == IDLE;
   assign busy       = state == DIV;

   // one restoring step: the top bit of the trial difference is the borrow
   assign rsh   = {rem, dq[DIV_W-1]};
   assign trial = rsh - {1'b0, dsr};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;

   always_comb begin
      next = (state == IDLE) ? (note_valid ? (pitch ? DIV : DONE) : IDLE) :
             (state == DIV)  ? ((bcnt == '0) ? DONE : DIV) : IDLE;
   end

   // dq starts as the dividend and shifts quotient bits in from the right
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dq        <= '0;
         rem       <= '0;
         dsr       <= '0;
         bcnt      <= '0;
         divnum    <= '0;
         div_valid <= 1'b0;
      end else begin
         div_valid <= state == DONE;
         if (state == IDLE && note_valid) begin
            dq   <= pitch ? DIVIDEND : '0;
            rem  <= '0;
            dsr  <= DIV_W'(freq);
            bcnt <= BW'(DIV_W - 1);
         end else if (state == DIV) begin
            dq   <= {dq[DIV_W-2:0], ~trial[DIV_W]};
            rem  <= trial[DIV_W] ? rsh[DIV_W-1:0] : trial[DIV_W-1:0];
            bcnt <= bcnt - BW'(1);
         end
         if (state == DONE) divnum <= dq;
      end

   // counter restarts when divnum updates, so a new pitch opens with its high phase
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         tone_out <= 1'b0;
      end else if (state == DONE || divnum <= DIV_W'(1)) begin
         cnt      <= '0;
         tone_out <= 1'b0;
      end else begin
         cnt      <= (cnt == divnum - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
         tone_out <= cnt < (divnum >> 1);
      end
endmodule

// File: tb/tb_tone_divgen.sv
// tb_tone_divgen: scoreboard bench for tone_divgen (default and small-parameter instances)
module tb_tone_divgen;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        nv = 1'b0, nv2 = 1'b0;
   logic [4:0]  nt = '0, nt2 = '0;
   logic        rdy, dv, bsy, tone, rdy2, dv2, bsy2, tone2;
   logic [31:0] divnum;
   logic [19:0] divnum2;

   always #5 clk = ~clk;

   tone_divgen u_dut (
      .clk(clk), .rst_n(rst_n), .note_valid(nv), .note(nt), .note_ready(rdy),
      .divnum(divnum), .div_valid(dv), .busy(bsy), .tone_out(tone)
   );

   tone_divgen #(.CLK_HZ(1_000_000), .DIV_W(20)) u_small (
      .clk(clk), .rst_n(rst_n), .note_valid(nv2), .note(nt2), .note_ready(rdy2),
      .divnum(divnum2), .div_valid(dv2), .busy(bsy2), .tone_out(tone2)
   );

   typedef struct {int exp_div; int exp_cyc;} exp_t;
   exp_t q1[$], q2[$];
   int checks = 0, failures = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (dv) begin
         if (q1.size() == 0) chk("main_unexpected_div_valid", dv, 0);
         else begin
            e = q1.pop_front();
            chk("main_divnum", divnum, e.exp_div);
            chk("main_latency_cycle", cyc, e.exp_cyc);
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (dv2) begin
         if (q2.size() == 0) chk("small_unexpected_div_valid", dv2, 0);
         else begin
            e = q2.pop_front();
            chk("small_divnum", divnum2, e.exp_div);
            chk("small_latency_cycle", cyc, e.exp_cyc);
         end
      end
   end

   task automatic send(input bit sel, input logic [4:0] n, input int exp, input int lat);
      @(negedge clk);
      chk(sel ? "small_note_ready" : "main_note_ready", sel ? rdy2 : rdy, 1);
      if (sel) begin q2.push_back('{exp, cyc + 1 + lat}); nv2 = 1'b1; nt2 = n; end
      else     begin q1.push_back('{exp, cyc + 1 + lat}); nv  = 1'b1; nt  = n; end
      @(negedge clk);
      nv = 1'b0; nv2 = 1'b0;
   endtask

   // returns in the negedge of the div_valid cycle; bc = busy cycles seen
   task automatic wait_done(input bit sel, output int bc);
      bc = 0;
      for (int i = 0; i < 200; i++) begin
         if ((sel ? q2.size() : q1.size()) == 0) return;
         if (sel ? bsy2 : bsy) bc++;
         @(negedge clk);
      end
      chk(sel ? "small_timeout_pending" : "main_timeout_pending", sel ? q2.size() : q1.size(), 0);
      q1.delete(); q2.delete();
   endtask

   initial begin
      int bc, hi, lo;
      repeat (3) @(negedge clk);
      chk("rst_divnum", divnum, 0);
      chk("rst_note_ready", rdy, 1);
      chk("rst_busy", bsy, 0);
      chk("rst_tone", tone, 0);
      chk("rst_div_valid", dv, 0);
      rst_n = 1'b1;

      send(0, 5'd6, 113636, 33); wait_done(0, bc);
      chk("busy_cycles_n6", bc, 32);
      @(negedge clk); chk("tone_high_after_update", tone, 1);
      send(0, 5'd1, 190839, 33);  wait_done(0, bc);
      send(0, 5'd21, 25303, 33);  wait_done(0, bc);
      send(0, 5'd11, 71530, 33);  wait_done(0, bc);
      repeat (5) @(negedge clk);
      send(0, 5'd0, 0, 1); wait_done(0, bc);
      chk("busy_cycles_rest0", bc, 0);
      @(negedge clk); chk("tone_low_after_rest0", tone, 0);
      send(0, 5'd6, 113636, 33); wait_done(0, bc);
      repeat (5) @(negedge clk);
      send(0, 5'd25, 0, 1); wait_done(0, bc);
      chk("busy_cycles_rest25", bc, 0);
      @(negedge clk); chk("tone_low_after_rest25", tone, 0);

      send(0, 5'd6, 113636, 33);
      nv = 1'b1; nt = 5'd13;
      repeat (5) @(negedge clk);
      nv = 1'b0;
      wait_done(0, bc);
      repeat (40) @(negedge clk);
      chk("ignored_req_divnum", divnum, 113636);

      send(0, 5'd6, 113636, 33);
      repeat (9) @(negedge clk);
      rst_n = 1'b0; q1.delete();
      #1;
      chk("midrst_divnum", divnum, 0);
      chk("midrst_busy", bsy, 0);
      chk("midrst_note_ready", rdy, 1);
      chk("midrst_tone", tone, 0);
      chk("midrst_div_valid", dv, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(negedge clk);
      send(0, 5'd13, 56818, 33); wait_done(0, bc);

      send(1, 5'd6, 2272, 21); wait_done(1, bc);
      chk("small_busy_cycles", bc, 20);
      @(negedge clk);
      hi = 0; while (tone2 && hi < 5000) begin hi++; @(negedge clk); end
      lo = 0; while (!tone2 && lo < 5000) begin lo++; @(negedge clk); end
      chk("small_tone_high", hi, 1136);
      chk("small_tone_low", lo, 1136);
      send(1, 5'd21, 506, 21); wait_done(1, bc);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
